// File: rtl/spi_cmd_parser.sv
// Byte-stream command parser for the SPI slave receiver: frames A5,cmd,d0..d3,chk
// and drives the frequency-counter controls with registered, one-cycle status pulses.
module spi_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned GATE_RST    = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] gate_time,
  output logic        meas_en,
  output logic        meas_start,
  output logic        cmd_ok,
  output logic        cmd_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_EXEC = 3'd4;

  localparam logic [7:0]  HEADER    = 8'hA5;
  localparam logic [19:0] TO_LAST   = 20'(TIMEOUT_CYC - 1);
  localparam logic [31:0] GATE_INIT = GATE_RST;

  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_CMD  = 2'b10;
  localparam logic [1:0] ERR_TOUT = 2'b11;

  logic [2:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [19:0] to_cnt_q, to_cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  xor_q, xor_d;
  logic        chk_ok_q, chk_ok_d;

  logic [31:0] gate_q, gate_d;
  logic        en_q, en_d;
  logic        start_q, start_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        busy_q, busy_d;

  logic in_frame;
  logic consume;
  logic timeout;

  assign in_frame = (state_q == S_CMD) || (state_q == S_DATA) || (state_q == S_CHK);
  assign consume  = rx_valid && (state_q != S_EXEC);
  // A byte arriving in the firing cycle wins over the timeout.
  assign timeout  = in_frame && !rx_valid && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    xor_d    = xor_q;
    chk_ok_d = chk_ok_q;
    gate_d   = gate_q;
    en_d     = en_q;
    code_d   = code_q;
    start_d  = 1'b0;
    ok_d     = 1'b0;
    err_d    = 1'b0;

    to_cnt_d = (consume || state_q == S_IDLE) ? '0 : to_cnt_q + 20'd1;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == HEADER) begin
          state_d = S_CMD;
          idx_d   = '0;
          cmd_d   = '0;
          data_d  = '0;
          xor_d   = '0;
        end
      end
      S_CMD: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          xor_d   = rx_data;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          data_d[{idx_q, 3'b000} +: 8] = rx_data;
          xor_d = xor_q ^ rx_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          chk_ok_d = (rx_data == xor_q);
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        if (!chk_ok_q) begin
          err_d  = 1'b1;
          code_d = ERR_CHK;
        end else begin
          case (cmd_q)
            8'h01: begin
              if (data_q != '0) begin
                gate_d = data_q;
                ok_d   = 1'b1;
              end else begin
                err_d  = 1'b1;
                code_d = ERR_CMD;
              end
            end
            8'h02: begin
              en_d = data_q[0];
              ok_d = 1'b1;
            end
            8'h03: begin
              start_d = 1'b1;
              ok_d    = 1'b1;
            end
            default: begin
              err_d  = 1'b1;
              code_d = ERR_CMD;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cmd_d   = '0;
      data_d  = '0;
      xor_d   = '0;
      err_d   = 1'b1;
      code_d  = ERR_TOUT;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      to_cnt_q <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      xor_q    <= '0;
      chk_ok_q <= 1'b0;
      gate_q   <= GATE_INIT;
      en_q     <= 1'b0;
      start_q  <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      xor_q    <= xor_d;
      chk_ok_q <= chk_ok_d;
      gate_q   <= gate_d;
      en_q     <= en_d;
      start_q  <= start_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
    end
  end

  assign gate_time  = gate_q;
  assign meas_en    = en_q;
  assign meas_start = start_q;
  assign cmd_ok     = ok_q;
  assign cmd_err    = err_q;
  assign err_code   = code_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Scoreboard bench for spi_cmd_parser: a frame-level reference model queues the
// expected status event per frame/timeout; a monitor compares when the DUT reports.
module tb_spi_cmd_parser;

  localparam int unsigned T    = 16;
  localparam logic [31:0] GATE = 32'd50000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [31:0] gate_time;
  logic        meas_en, meas_start, cmd_ok, cmd_err, busy;
  logic [1:0]  err_code;

  spi_cmd_parser #(.TIMEOUT_CYC(T), .GATE_RST(GATE)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .gate_time(gate_time), .meas_en(meas_en), .meas_start(meas_start),
    .cmd_ok(cmd_ok), .cmd_err(cmd_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        ok;
    logic        start;
    logic [31:0] gate;
    logic        en;
    logic [1:0]  err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic done = 1'b0;

  // Reference model: position within frame, collected bytes, last consumed cycle.
  int          m_idx;
  logic [7:0]  m_fr[7];
  int          m_last;
  int          m_exec;
  logic [31:0] m_gate;
  logic        m_en;
  logic [1:0]  m_err;

  function automatic void model_reset();
    m_idx = 0; m_last = 0; m_exec = -1;
    m_gate = GATE; m_en = 1'b0; m_err = 2'b00;
  endfunction

  function automatic void push(input int due, input logic ok, input logic start);
    exp_t e;
    e.due = due; e.ok = ok; e.start = start;
    e.gate = m_gate; e.en = m_en; e.err = m_err;
    exp_q.push_back(e);
  endfunction

  // No byte reaches the DUT before cycle c.
  function automatic void model_advance(input int c);
    if (m_idx != 0 && c > m_last + int'(T)) begin
      m_err = 2'b11;
      push(m_last + int'(T) + 1, 1'b0, 1'b0);
      m_idx = 0;
    end
  endfunction

  function automatic void model_eval(input int c);
    logic [7:0]  x;
    logic [31:0] val;
    x   = m_fr[1] ^ m_fr[2] ^ m_fr[3] ^ m_fr[4] ^ m_fr[5];
    val = {m_fr[5], m_fr[4], m_fr[3], m_fr[2]};
    if (x != m_fr[6]) begin
      m_err = 2'b01; push(c + 2, 1'b0, 1'b0);
    end else if (m_fr[1] == 8'h01 && val != 0) begin
      m_gate = val; push(c + 2, 1'b1, 1'b0);
    end else if (m_fr[1] == 8'h02) begin
      m_en = m_fr[2][0]; push(c + 2, 1'b1, 1'b0);
    end else if (m_fr[1] == 8'h03) begin
      push(c + 2, 1'b1, 1'b1);
    end else begin
      m_err = 2'b10; push(c + 2, 1'b0, 1'b0);
    end
  endfunction

  function automatic void model_byte(input int c, input logic [7:0] b);
    model_advance(c);
    if (c == m_exec) return;
    m_last = c;
    if (m_idx == 0) begin
      if (b == 8'hA5) begin m_fr[0] = b; m_idx = 1; end
    end else begin
      m_fr[m_idx] = b;
      m_idx++;
      if (m_idx == 7) begin
        model_eval(c);
        m_idx  = 0;
        m_exec = c + 1;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    model_byte(cyc + int'(gap) + 1, b);
    repeat (gap) begin
      @(negedge clk); rx_valid = 1'b0; rx_data = 8'($urandom);
    end
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
  endtask

  task automatic idle(input int unsigned n);
    model_advance(cyc + int'(n) + 1);
    repeat (n) begin
      @(negedge clk); rx_valid = 1'b0; rx_data = 8'($urandom);
    end
  endtask

  task automatic send_frame(input logic [55:0] fr, input int unsigned gap);
    for (int i = 0; i < 7; i++) send_byte(fr[8*(6-i) +: 8], gap);
  endtask

  function automatic int unsigned rgap();
    int unsigned r;
    r = $urandom_range(0, 59);
    if (r == 0) return T - 1;
    if (r == 1) return T;
    return r % 3;
  endfunction

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0; rx_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: reset values while in reset, otherwise event matching plus held-register checks.
  initial begin : monitor
    logic [31:0] e_gate;
    logic        e_en;
    logic [1:0]  e_err;
    logic        fin;
    exp_t        e;
    fin = 1'b0;
    e_gate = GATE; e_en = 1'b0; e_err = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        e_gate = GATE; e_en = 1'b0; e_err = 2'b00;
        check("rst_gate_time", gate_time, GATE);
        check("rst_meas_en", {31'd0, meas_en}, 32'd0);
        check("rst_meas_start", {31'd0, meas_start}, 32'd0);
        check("rst_cmd_ok", {31'd0, cmd_ok}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
      end else begin
        if (cmd_ok && cmd_err) check("ok_err_exclusive", 32'd1, 32'd0);
        if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
          check("missed_event_cycle", cyc, exp_q[0].due);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          e_gate = e.gate; e_en = e.en; e_err = e.err;
          check("cmd_ok", {31'd0, cmd_ok}, {31'd0, e.ok});
          check("cmd_err", {31'd0, cmd_err}, {31'd0, !e.ok});
          check("meas_start", {31'd0, meas_start}, {31'd0, e.start});
          check("busy_after_event", {31'd0, busy}, 32'd0);
        end else if (cmd_ok || cmd_err || meas_start) begin
          check("unexpected_pulse", {29'd0, cmd_ok, cmd_err, meas_start}, 32'd0);
        end
        check("gate_time", gate_time, e_gate);
        check("meas_en", {31'd0, meas_en}, {31'd0, e_en});
        check("err_code", {30'd0, err_code}, {30'd0, e_err});
      end
      if (done && !fin) begin
        fin = 1'b1;
        check("pending_events", exp_q.size(), 32'd0);
      end
    end
  end

  initial begin : stim
    logic [7:0]  cmd, c;
    logic [31:0] d;
    logic [7:0]  junk;
    int unsigned r, k;
    model_reset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed scenarios
    send_frame(56'hA5_01_40_42_0F_00_0C, 0);
    idle(4);
    send_frame(56'hA5_02_01_00_00_00_03, 1);
    send_frame(56'hA5_03_00_00_00_00_03, 0);
    idle(3);
    send_frame(56'hA5_01_40_42_0F_00_0D, 0);
    send_frame(56'hA5_07_00_00_00_00_07, 2);
    idle(3);
    send_byte(8'h33, 2);
    send_byte(8'hA5, 1);
    send_byte(8'h01, 0);
    idle(T + 4);
    send_frame(56'hA5_01_10_00_00_00_11, 0);
    idle(3);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h40, 0);
    do_reset();
    send_frame(56'hA5_01_40_42_0F_00_0C, 0);
    idle(3);
    send_frame(56'hA5_01_00_00_00_00_01, 0);
    idle(3);
    do_reset();
    send_frame(56'hA5_01_00_00_00_00_01, 0);
    // Timeout boundary: gap T-1 is cancelled by the byte, gap T expires.
    send_byte(8'hA5, 2); send_byte(8'h02, 0); send_byte(8'h01, T - 1);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'hA5, 2); send_byte(8'h02, 0); send_byte(8'h00, T);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
    idle(T + 3);
    // Byte landing in the execute cycle is dropped.
    send_frame(56'hA5_02_01_00_00_00_03, 0);
    send_byte(8'hA5, 0);
    send_frame(56'hA5_02_00_00_00_00_02, 0);
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk, $urandom_range(0, 3));
      end else if (r == 1) begin
        k = $urandom_range(0, 5);
        send_byte(8'hA5, $urandom_range(0, 2));
        for (int i = 0; i < int'(k); i++) send_byte(8'($urandom), $urandom_range(0, 2));
        idle(T + $urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 4))
          0, 1: cmd = 8'h01;
          2: cmd = 8'h02;
          3: cmd = 8'h03;
          default: cmd = 8'($urandom);
        endcase
        d = $urandom;
        if (cmd == 8'h01 && $urandom_range(0, 7) == 0) d = '0;
        c = cmd ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
        if ($urandom_range(0, 5) == 0) c = c ^ 8'($urandom_range(1, 255));
        send_byte(8'hA5, rgap());
        send_byte(cmd, rgap());
        send_byte(d[7:0], rgap());
        send_byte(d[15:8], rgap());
        send_byte(d[23:16], rgap());
        send_byte(d[31:24], rgap());
        send_byte(c, rgap());
        if ($urandom_range(0, 4) == 0) send_byte(8'hA5, 0);
      end
    end

    idle(T + 8);
    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spi_cmd_parser.md
SPI_CMD_PARSER -- requirements
Module: spi_cmd_parser

Interface
REQ-001 Parameters SHALL be exactly (name, default, meaning):
- TIMEOUT_CYC, 50000, inter-byte timeout in clk cycles (1 ms at 50 MHz), legal 2..2^20-1.
- GATE_RST, 50000000, reset value of gate_time.
REQ-002 Ports SHALL be exactly (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- rx_data, in, 8, received byte from the SPI slave receiver; valid only while rx_valid=1.
- rx_valid, in, 1, one-cycle byte strobe (receiver finish pulse).
- gate_time, out, 32, measurement gate length in clk cycles.
- meas_en, out, 1, frequency counter enable.
- meas_start, out, 1, one-cycle measurement start pulse.
- cmd_ok, out, 1, one-cycle pulse, frame executed.
- cmd_err, out, 1, one-cycle pulse, frame rejected.
- err_code, out, 2, reason for last rejection: 01 checksum, 10 bad command/value, 11 timeout; held until the next rejection.
- busy, out, 1, high while a frame is in progress (state not IDLE).

Function
REQ-003 Frame SHALL be 7 bytes in order: header 0xA5, cmd, d0, d1, d2, d3, chk; chk = cmd^d0^d1^d2^d3.
REQ-004 Bytes SHALL be consumed only in cycles with rx_valid=1; rx_data in other cycles SHALL be ignored.
REQ-005 FSM states SHALL be IDLE, CMD, DATA, CHK, EXEC:
- IDLE: a byte equal to 0xA5 -> CMD; any other byte is dropped silently, no cmd_err.
- CMD: latch cmd -> DATA, byte index 0.
- DATA: latch byte at index 0..3 into data[8*i+7:8*i] (d0 = LSB); after index 3 -> CHK.
- CHK: compare byte with running XOR; latch the result -> EXEC.
- EXEC: one cycle, executes or rejects -> IDLE unconditionally.
REQ-006 A 0xA5 byte in CMD/DATA/CHK SHALL be treated as ordinary payload, not as a frame restart.
REQ-007 An rx_valid during EXEC SHALL be dropped.
REQ-008 Commands:
- 0x01: gate_time <= {d3,d2,d1,d0}.
- 0x02: meas_en <= d0[0]; other bits ignored.
- 0x03: meas_start pulse; data bytes ignored.
REQ-009 Rejections (no register change, no meas_start):
- checksum mismatch -> err_code 01;
- cmd not in {0x01,0x02,0x03}, or cmd 0x01 with value 0 -> err_code 10.
- Checksum failure SHALL take priority over a bad command.
REQ-010 Latency: the checksum byte's rx_valid in cycle T SHALL produce cmd_ok or cmd_err high in cycle T+2 only. gate_time/meas_en SHALL show the new value from T+2, and meas_start SHALL be high in T+2 only.
REQ-011 Timeout: a 20-bit counter SHALL clear on every consumed rx_valid and in IDLE, and SHALL increment otherwise. When it reaches TIMEOUT_CYC-1 in CMD/DATA/CHK, the FSM SHALL go to IDLE, pulse cmd_err the next cycle with err_code 11, and discard partial data.
REQ-012 rx_valid in the same cycle that the timeout fires SHALL be consumed and SHALL cancel the timeout.
REQ-013 cmd_ok and cmd_err SHALL never be high in the same cycle. Each pulse SHALL last exactly one cycle, as SHALL meas_start.
REQ-014 busy SHALL be high in CMD, DATA, CHK and EXEC.
REQ-015 All outputs SHALL be registered, with no combinational path from rx_data/rx_valid.

Reset
REQ-016 On rst_n low, at any time including mid-frame, the block SHALL apply:
- state IDLE, byte index 0, timeout counter 0, partial data discarded;
- gate_time = GATE_RST, meas_en = 0, meas_start = 0, cmd_ok = 0, cmd_err = 0, err_code = 00, busy = 0.
REQ-017 Reset release SHALL take effect synchronously on the first clk edge after rst_n rises, and the first frame after release SHALL parse normally.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- A5 01 40 42 0F 00 0C -> cmd_ok at T+2, gate_time = 0x000F4240 (1000000), no cmd_err.
- A5 02 01 00 00 00 03 then A5 03 00 00 00 00 03 -> meas_en = 1, then a single meas_start pulse; both frames give cmd_ok.
- A5 01 40 42 0F 00 0D (bad chk) -> cmd_err, err_code = 01, gate_time unchanged. Then A5 07 00 00 00 00 07 -> err_code = 10.
- 33 A5 01 (stall > TIMEOUT_CYC) -> cmd_err, err_code = 11, busy falls. A following valid frame executes; the leading 0x33 produces no error.
- rst_n pulsed low after A5 01 40 -> all outputs at reset values. The full frame resent after release executes correctly.
- A5 01 00 00 00 00 01 (zero gate) -> cmd_err, err_code = 10, gate_time stays at GATE_RST.
